// File: rtl/calc_writeback.sv
// Result writeback: buffers 8-lane adder result vectors in a small FIFO and
// drains them lane by lane to B memory. Optional macro CALC_WB_MODQ_EN keeps lane[15:0] only.
module calc_writeback #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [31:0]      cfg_base_addr,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [7:0][16:0] res_data,
  output logic             mem_wr_en,
  input  logic             mem_wr_ready,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  output logic             busy,
  output logic [15:0]      vec_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [7:0][16:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [2:0]        lane;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [15:0]       vec_cnt_q;
  logic [16:0]       head_lane;
  logic              push, accept, pop;

  function automatic logic [31:0] lane_fmt(input logic [16:0] v);
`ifdef CALC_WB_MODQ_EN
    return {16'b0, v[15:0]};
`else
    return {15'b0, v};
`endif
  endfunction

  assign res_ready = (count != FULL_CNT);
  assign push      = res_valid && res_ready;
  assign accept    = (state == WRITE) && mem_wr_ready;
  assign pop       = accept && (lane == 3'd7);
  assign head_lane = fifo_mem[rd_ptr][lane];

  assign mem_wr_en   = (state == WRITE);
  assign mem_wr_addr = addr_q;
  // While idle the last written value is presented, not whatever sits at the head.
  assign mem_wr_data = mem_wr_en ? lane_fmt(head_lane) : data_q;
  assign busy        = (count != '0) || (state == WRITE);
  assign vec_count   = vec_cnt_q;

  // Going to WRITE on the push itself gives lane 0 the cycle after an empty-FIFO push.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((count != '0) || push) state_nxt = WRITE;
      WRITE:   if (pop && (count == (AW+1)'(1)) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lane      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      vec_cnt_q <= '0;
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lane      <= '0;
      addr_q    <= cfg_base_addr;
      vec_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        vec_cnt_q <= vec_cnt_q + 16'd1;
      end
      if (accept) begin
        lane   <= lane + 3'd1;
        addr_q <= addr_q + 32'(ADDR_STRIDE);
        data_q <= lane_fmt(head_lane);
      end
    end
  end

  // Vector storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) fifo_mem[wr_ptr] <= res_data;
  end

endmodule

// File: tb/tb_calc_writeback.sv
// Directed self-checking bench for calc_writeback (FIFO_DEPTH=4, ADDR_STRIDE=4).
module tb_calc_writeback;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [31:0]      cfg_base_addr;
  logic             res_valid;
  logic             res_ready;
  logic [7:0][16:0] res_data;
  logic             mem_wr_en;
  logic             mem_wr_ready;
  logic [31:0]      mem_wr_addr;
  logic [31:0]      mem_wr_data;
  logic             busy;
  logic [15:0]      vec_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int          log_cyc  [256];
  int          wr_cnt = 0;
  int          cyc = 0;

`ifdef CALC_WB_MODQ_EN
  localparam logic [31:0] EXP_MAX = 32'h0000FFFF;
`else
  localparam logic [31:0] EXP_MAX = 32'h0001FFFF;
`endif

  calc_writeback #(.FIFO_DEPTH(4), .ADDR_STRIDE(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_base_addr(cfg_base_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: logs every accepted write with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && mem_wr_en && mem_wr_ready && wr_cnt < 256) begin
      log_addr[wr_cnt] <= mem_wr_addr;
      log_data[wr_cnt] <= mem_wr_data;
      log_cyc[wr_cnt]  <= cyc;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][16:0] mkvec(input int b);
    logic [7:0][16:0] v;
    for (int l = 0; l < 8; l++) v[l] = 17'(b + l);
    return v;
  endfunction

  task automatic push(input logic [7:0][16:0] v);
    res_valid = 1'b1;
    res_data  = v;
    step();
    res_valid = 1'b0;
  endtask

  task automatic do_clear(input logic [31:0] base);
    clear         = 1'b1;
    cfg_base_addr = base;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (wr_cnt < target && n < 300) begin
      step();
      n++;
    end
    check(tag, 32'(wr_cnt >= target), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int wc;
    logic [7:0][16:0] v;

    rst_n = 1'b0; clear = 1'b0; cfg_base_addr = '0;
    res_valid = 1'b0; res_data = '0; mem_wr_ready = 1'b0;
    #12;
    check("rst_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", mem_wr_addr, 32'd0);
    check("rst_data", mem_wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vec", 32'(vec_count), 32'd0);
    check("rst_ready", 32'(res_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single vector, memory always ready
    do_clear(32'h1000);
    check("clr_addr", mem_wr_addr, 32'h1000);
    mem_wr_ready = 1'b1;
    base = wr_cnt;
    push(mkvec(1));
    check("first_en", 32'(mem_wr_en), 32'd1);
    check("first_data", mem_wr_data, 32'd1);
    wait_writes(base + 8, "v1_done");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v1_addr%0d", i), log_addr[base+i], 32'h1000 + 32'(4*i));
      check($sformatf("v1_data%0d", i), log_data[base+i], 32'(i + 1));
    end
    check("v1_vec", 32'(vec_count), 32'd1);
    check("v1_busy", 32'(busy), 32'd0);
    check("v1_idle_en", 32'(mem_wr_en), 32'd0);

    // Backpressure on lane 2
    do_clear(32'h2000);
    mem_wr_ready = 1'b0;
    base = wr_cnt;
    push(mkvec(16));
    mem_wr_ready = 1'b1;
    step();
    step();
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_wr_ready = 1'b1;
      check($sformatf("stall_addr%0d", i), mem_wr_addr, 32'h2008);
      check($sformatf("stall_data%0d", i), mem_wr_data, 32'h12);
      check($sformatf("stall_en%0d", i), 32'(mem_wr_en), 32'd1);
      step();
    end
    wait_writes(base + 8, "stall_done");
    step();
    step();
    check("stall_nwr", 32'(wr_cnt - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("stall_log%0d", i), log_addr[base+i], 32'h2000 + 32'(4*i));

    // Fill the FIFO while memory stalls, then drain 40 writes
    do_clear(32'h3000);
    mem_wr_ready = 1'b0;
    base = wr_cnt;
    res_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      res_data = mkvec(16*k);
      step();
    end
    check("full_ready0", 32'(res_ready), 32'd0);
    res_data = mkvec(64);
    step();
    step();
    check("full_held", 32'(res_ready), 32'd0);
    check("full_nowr", 32'(wr_cnt - base), 32'd0);
    mem_wr_ready = 1'b1;
    n = 0;
    while (!res_ready && n < 100) begin
      step();
      n++;
    end
    check("full_reopen", 32'(res_ready), 32'd1);
    step();
    res_valid = 1'b0;
    wait_writes(base + 40, "full_done");
    for (int i = 0; i < 40; i++) begin
      check($sformatf("full_addr%0d", i), log_addr[base+i], 32'h3000 + 32'(4*i));
      check($sformatf("full_data%0d", i), log_data[base+i], 32'(16*(i/8) + (i%8)));
    end
    check("full_nogap", 32'(log_cyc[base+39] - log_cyc[base]), 32'd39);
    check("full_vec", 32'(vec_count), 32'd5);

    // Widest lane value
    do_clear(32'h4000);
    base = wr_cnt;
    v = '0;
    v[0] = 17'h1FFFF;
    push(v);
    check("max_data", mem_wr_data, EXP_MAX);
    wait_writes(base + 8, "max_done");
    check("max_log", log_data[base], EXP_MAX);
    check("max_vec", 32'(vec_count), 32'd1);

    // Clear mid-vector with a same-cycle push
    push(mkvec(32));
    step();
    step();
    step();
    check("mid_addr", mem_wr_addr, 32'h402C);
    check("mid_data", mem_wr_data, 32'h23);
    clear = 1'b1;
    cfg_base_addr = 32'h6000;
    res_valid = 1'b1;
    res_data = mkvec(99);
    step();
    clear = 1'b0;
    res_valid = 1'b0;
    check("clr_en", 32'(mem_wr_en), 32'd0);
    check("clr_ready", 32'(res_ready), 32'd1);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_vec", 32'(vec_count), 32'd0);
    check("clr_addr2", mem_wr_addr, 32'h6000);
    push(mkvec(48));
    base = wr_cnt;
    check("post_clr_addr", mem_wr_addr, 32'h6000);
    check("post_clr_data", mem_wr_data, 32'h30);
    wait_writes(base + 8, "post_clr_done");
    check("post_clr_vec", 32'(vec_count), 32'd1);

    // Asynchronous reset during lane 5
    push(mkvec(64));
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_addr", mem_wr_addr, 32'h6034);
    rst_n = 1'b0;
    #1;
    check("arst_en", 32'(mem_wr_en), 32'd0);
    check("arst_addr", mem_wr_addr, 32'd0);
    check("arst_data", mem_wr_data, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_vec", 32'(vec_count), 32'd0);
    check("arst_ready", 32'(res_ready), 32'd1);
    wc = wr_cnt;
    step();
    step();
    check("arst_nowr", 32'(wr_cnt - wc), 32'd0);
    rst_n = 1'b1;
    step();
    do_clear(32'h7000);
    push(mkvec(80));
    base = wr_cnt;
    wait_writes(base + 8, "rel_done");
    check("rel_addr", log_addr[base], 32'h7000);
    check("rel_data", log_data[base], 32'h50);
    check("rel_last", log_addr[base+7], 32'h701C);
    check("rel_vec", 32'(vec_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
